// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
// Optional feature macro: MULTDIV_PERF_EN (stall-cycle counter).
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  REG_RSTATUS = 5'd30;
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  function automatic logic [31:0] rstatus_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MUL;
  endfunction

endpackage

// File: rtl/muldiv_busy_timer.sv
// BUSY-phase cycle counter for the mult/div sequencer.
// Flags the last permitted BUSY cycle (TIMEOUT-1).
module muldiv_busy_timer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  // count BUSY cycles; clear has priority over enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage controller for the shared multi-cycle mult/div unit.
// Optional feature macro: MULTDIV_PERF_EN (perf_stall_cycles counter).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic [4:0]  dx_rd,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        res_valid,
  output logic [4:0]  res_reg,
  output logic [31:0] res_data,
  output logic [31:0] perf_stall_cycles
);

  state_t      state_q;
  state_t      state_d;
  logic        issue;
  logic        capture;
  logic        exc_now;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_hit;
  logic        op_div_q;
  logic [4:0]  rd_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [4:0]  res_reg_q;
  logic [31:0] res_data_q;

  // a new op may only launch from IDLE and never while in reset
  assign issue = reset && (state_q == IDLE)
              && (dx_is_mult || dx_is_div) && !flush;

  assign capture = (state_q == BUSY) && !flush
                && (md_resultRDY || timer_hit);

  // a real RDY beats the timeout; timeout alone is an exception
  assign exc_now = md_resultRDY ? md_exception : 1'b1;

  muldiv_busy_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clr),
    .enable(timer_en),
    .hit   (timer_hit)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and timer control
  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (issue) state_d = START;
      end
      START: begin
        timer_clr = 1'b1;
        state_d   = flush ? IDLE : BUSY;
      end
      BUSY: begin
        timer_en = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY || timer_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // operand latch on issue, writeback bundle on completion
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_div_q   <= 1'b0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_reg_q  <= '0;
      res_data_q <= '0;
    end else begin
      if (issue) begin
        op_div_q <= !dx_is_mult;
        rd_q     <= dx_rd;
        opa_q    <= dx_opA;
        opb_q    <= dx_opB;
      end
      if (capture) begin
        res_reg_q  <= exc_now ? REG_RSTATUS : rd_q;
        res_data_q <= exc_now ? rstatus_code(op_div_q)
                              : md_result;
      end
    end
  end

  assign md_ctrl_mult = (state_q == START) && !flush && !op_div_q;
  assign md_ctrl_div  = (state_q == START) && !flush && op_div_q;
  assign md_opA       = opa_q;
  assign md_opB       = opb_q;
  assign stall        = issue || (state_q == START)
                     || (state_q == BUSY);
  assign res_valid    = (state_q == DONE);
  assign res_reg      = res_reg_q;
  assign res_data     = res_data_q;

`ifdef MULTDIV_PERF_EN
  logic [31:0] perf_q;

  // wrapping count of stalled cycles
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (stall) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Controls the shared multi-cycle multiply/divide unit from the execute stage of the 5-stage pipeline. It detects a mult/div instruction in the DX latch and launches the unit with a one-cycle control pulse. It freezes PC, FD and DX while the unit works, then hands the result, or an r30 exception status, to the XM latch for one cycle.

Parameters:
TIMEOUT, 40, max BUSY cycles before the operation is forced to complete with an exception
CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  input  1  single pipeline clock, rising edge
reset  input  1  synchronous, active-low; 0 = reset on next rising edge
dx_is_mult  input  1  DX instruction is mul
dx_is_div  input  1  DX instruction is div
dx_opA  input  32  rs value after bypass muxing
dx_opB  input  32  rt value after bypass muxing
dx_rd  input  5  destination register of the DX instruction
flush  input  1  branch/jump flush of DX this cycle
md_resultRDY  input  1  multdiv unit result ready
md_result  input  32  multdiv unit result
md_exception  input  1  multdiv overflow or divide-by-zero
md_ctrl_mult  output  1  one-cycle start pulse, multiply
md_ctrl_div  output  1  one-cycle start pulse, divide
md_opA  output  32  registered operand A to the unit
md_opB  output  32  registered operand B to the unit
stall  output  1  freeze PC/FD/DX and insert a bubble into XM
res_valid  output  1  one-cycle: result is written into XM this cycle
res_reg  output  5  writeback register (dx_rd, or 5'd30 on exception)
res_data  output  32  writeback data (result, or rstatus code)
perf_stall_cycles  output  32  see Optional Feature

Behaviour:
- States: IDLE, START, BUSY, DONE.
- Reset (reset=0 at an edge):
  - state=IDLE, counter=0.
  - All outputs 0, including md_opA/md_opB and latched rd/op/exc.
  - Reset mid-operation abandons the operation. Any later md_resultRDY seen in IDLE is ignored.
- issue = IDLE & (dx_is_mult|dx_is_div) & !flush. If both dx_is_mult and dx_is_div are high, treat as mult.
- IDLE:
  - On issue: latch opA/opB/rd/op-type, go to START.
  - stall is combinational: stall = issue | (state==START) | (state==BUSY). stall rises in the issue cycle itself.
- START:
  - Exactly one cycle, with md_ctrl_mult or md_ctrl_div = 1 according to the latched op.
  - md_opA/md_opB are stable from START until DONE. Counter is cleared. Go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - md_resultRDY=1: capture md_result and md_exception, go to DONE.
  - Counter==TIMEOUT-1 without RDY: exc=1, go to DONE.
  - RDY in the same cycle as the timeout: RDY wins and its md_exception is used.
- DONE:
  - Exactly one cycle with stall=0 and res_valid=1.
  - exc=0: res_reg=latched rd, res_data=result.
  - exc=1: res_reg=30, res_data=4 for mult, 5 for div.
  - res_reg=0 without exception: res_valid still pulses; the register file discards the write.
  - Next state is IDLE. The mult/div is still in DX during DONE, but it is never reissued because issue requires IDLE.
- res_reg and res_data are held in IDLE as well, so res_valid alone gates them.
- flush in START or BUSY: return to IDLE, stall drops the next cycle, no res_valid, no ctrl pulse. A stale RDY is dropped.
- flush in DONE is ignored; the result still commits.
- Minimum occupancy with RDY in the first BUSY cycle: issue, START, BUSY, DONE = stall held 3 cycles.

Optional Feature:
MULTDIV_PERF_EN
- Defined: perf_stall_cycles is a wrapping 32-bit counter, cleared by reset, that increments every cycle stall=1.
- Undefined: perf_stall_cycles is tied to 32'd0 and no counter logic is built.

Decomposition:
- muldiv_pkg holds:
  - state encoding (2-bit enum IDLE/START/BUSY/DONE)
  - REG_RSTATUS=5'd30
  - RSTATUS_MUL=32'd4, RSTATUS_DIV=32'd5
- One sub-module: muldiv_busy_timer. It holds the CNT_W counter with clear and enable inputs and a hit output for TIMEOUT-1.

Test Plan:
- Reset: hold reset=0 for 2 cycles with dx_is_mult=1 -> stall=0, no ctrl pulse, all outputs 0.
- Mult: opA=7, opB=6, rd=3; RDY with result 42 on the 5th BUSY cycle -> one md_ctrl_mult pulse in the cycle after issue; stall=1 for 7 cycles; then res_valid=1, res_reg=3, res_data=42.
- Div by zero: opB=0, rd=9; RDY with md_exception=1 -> res_reg=30, res_data=5, res_valid for one cycle.
- Timeout: div issued and RDY never asserted, TIMEOUT=40 -> DONE entered after 40 BUSY cycles; res_reg=30, res_data=5; stall returns to 0.
- Flush: flush=1 on the 2nd BUSY cycle, then a stale RDY 3 cycles later -> IDLE, no res_valid. Flush in the issue cycle -> no START at all.
- Back-to-back: mult then div in consecutive instructions -> div issues the cycle after DONE; two distinct ctrl pulses; no reissue of the mult. With MULTDIV_PERF_EN, perf_stall_cycles equals the total stalled cycles.
